// File: rtl/oc15_frame_acc.sv
// Frame accumulator for the 15-input ones counter.
// Collects FRAME_LEN ones-counts per frame and reports a saturated sum, the maximum and
// minimum counts, a saturation flag and an over-threshold flag. A frame result is held
// until the downstream consumer takes it, and input is stalled in the meantime.
module oc15_frame_acc #(
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned SUM_W     = 8,
    parameter int unsigned THRESH    = 120
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       cnt_in,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] sum_out,
    output logic [3:0]       max_out,
    output logic [3:0]       min_out,
    output logic             sat_out,
    output logic             over_thresh,
    output logic [7:0]       frame_no
);

    // Reject out-of-range parameters at elaboration time.
    if (FRAME_LEN < 1 || FRAME_LEN > 255) begin : g_bad_frame_len
        $error("oc15_frame_acc: FRAME_LEN must be in 1..255");
    end
    if (SUM_W < 4 || SUM_W > 16) begin : g_bad_sum_w
        $error("oc15_frame_acc: SUM_W must be in 4..16");
    end

    typedef enum logic {
        StAcc  = 1'b0,
        StHold = 1'b1
    } state_t;

    localparam logic [SUM_W-1:0] SumMax  = {SUM_W{1'b1}};
    localparam logic [SUM_W-1:0] ThreshV = SUM_W'(THRESH);
    // Index of the final word of a frame; zero when FRAME_LEN is 1, so the first word
    // of such a frame is also its last.
    localparam logic [7:0]       LastIdx = 8'(FRAME_LEN - 1);

    state_t           state;
    logic [7:0]       word_idx;
    logic [SUM_W-1:0] acc_sum;
    logic [3:0]       acc_max;
    logic [3:0]       acc_min;
    logic             acc_sat;

    logic             first_word;
    logic             last_word;
    logic [SUM_W:0]   sum_wide;
    logic [SUM_W-1:0] sum_nxt;
    logic [3:0]       max_nxt;
    logic [3:0]       min_nxt;
    logic             sat_nxt;
    logic             over_nxt;

    // Handshake flags are decoded straight from the state register.
    assign in_ready  = (state == StAcc);
    assign out_valid = (state == StHold);

    // Accumulator values that would result from accepting cnt_in this cycle.
    always_comb begin
        first_word = (word_idx == 8'd0);
        last_word  = (word_idx == LastIdx);
        // One extra bit catches the carry out so the sum clips instead of wrapping.
        sum_wide   = {1'b0, acc_sum} + (SUM_W+1)'(cnt_in);
        sum_nxt    = acc_sum;
        max_nxt    = acc_max;
        min_nxt    = acc_min;
        sat_nxt    = acc_sat;
        if (first_word) begin
            sum_nxt = SUM_W'(cnt_in);
            max_nxt = cnt_in;
            min_nxt = cnt_in;
            sat_nxt = 1'b0;
        end else begin
            if (sum_wide[SUM_W]) begin
                sum_nxt = SumMax;
                sat_nxt = 1'b1;
            end else begin
                sum_nxt = sum_wide[SUM_W-1:0];
            end
            if (cnt_in > acc_max) begin
                max_nxt = cnt_in;
            end
            if (cnt_in < acc_min) begin
                min_nxt = cnt_in;
            end
        end
        over_nxt = (sum_nxt > ThreshV);
    end

    // Frame FSM, accumulators and registered frame results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= StAcc;
            word_idx    <= 8'd0;
            acc_sum     <= '0;
            acc_max     <= 4'd0;
            acc_min     <= 4'd0;
            acc_sat     <= 1'b0;
            sum_out     <= '0;
            max_out     <= 4'd0;
            min_out     <= 4'd0;
            sat_out     <= 1'b0;
            over_thresh <= 1'b0;
            frame_no    <= 8'd0;
        end else begin
            unique case (state)
                StAcc: begin
                    if (in_valid) begin
                        acc_sum  <= sum_nxt;
                        acc_max  <= max_nxt;
                        acc_min  <= min_nxt;
                        acc_sat  <= sat_nxt;
                        word_idx <= word_idx + 8'd1;
                        if (last_word) begin
                            sum_out     <= sum_nxt;
                            max_out     <= max_nxt;
                            min_out     <= min_nxt;
                            sat_out     <= sat_nxt;
                            over_thresh <= over_nxt;
                            state       <= StHold;
                        end
                    end
                end
                StHold: begin
                    // Result registers stay frozen until the consumer takes them.
                    if (out_ready) begin
                        state    <= StAcc;
                        word_idx <= 8'd0;
                        frame_no <= frame_no + 8'd1;
                    end
                end
                default: begin
                    state <= StAcc;
                end
            endcase
        end
    end

endmodule
